hard_mem_1rw_req_adapter: RTL
=============================

Name: hard_mem_1rw_req_adapter

Overview:
- Request-side front end that drives the active-high 1rw bit-mask hard-memory wrapper port (v/w/addr/data/w_mask) from a valid/ready client.
- Tracks the one-cycle macro read latency, captures read data into a small response FIFO, and applies backpressure, so clients never sample raw macro outputs.
- Sits between cache/tag logic and the hard memory wrappers.
- Optionally sweeps the array to zero after reset.

Parameters:
- width_p, 64, data and bit-mask width
- els_p, 512, memory depth
- addr_width_lp, $clog2(els_p), address width (derived)
- resp_els_p, 3, response FIFO depth (>=3 gives full read throughput)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- v_i  in  1  client request valid
- ready_o  out  1  adapter can accept request
- w_i  in  1  1=write, 0=read
- addr_i  in  addr_width_lp  request address
- data_i  in  width_p  write data
- w_mask_i  in  width_p  per-bit write enable, 1=write bit
- v_o  out  1  read response valid
- data_o  out  width_p  read response data
- yumi_i  in  1  client consumes response (only legal when v_o=1)
- mem_v_o  out  1  to wrapper v_i
- mem_w_o  out  1  to wrapper w_i
- mem_addr_o  out  addr_width_lp  to wrapper addr_i
- mem_data_o  out  width_p  to wrapper data_i
- mem_w_mask_o  out  width_p  to wrapper w_mask_i
- mem_data_i  in  width_p  from wrapper data_o
- init_done_o  out  1  array ready for client traffic

Behaviour:
- Interface: one clock (clk_i). Reset (reset_i) is synchronous and active-high.
- Reset values: ready_o=0, v_o=0, mem_v_o=0, mem_w_o=0, init_done_o=0, FIFO empty, inflight=0.
- States:
  - INIT: active only with the macro. Zero sweep; exits to READY.
  - READY: normal operation.
  - After reset deasserts, without the macro, the block enters READY on the next cycle and sets init_done_o=1.
- Request handshake:
  - A request is accepted when v_i & ready_o.
  - ready_o = init_done_o & (occ + inflight < resp_els_p).
  - ready_o has no combinational dependence on v_i or yumi_i.
- Issue:
  - On acceptance, mem_v_o=1 in the same cycle.
  - mem_w_o/mem_addr_o/mem_data_o/mem_w_mask_o = w_i/addr_i/data_i/w_mask_i, combinational pass-through.
  - Otherwise mem_v_o=0.
  - mem_w_mask_o = 0 on reads.
- Read path:
  - Read accepted at cycle t sets inflight=1 for cycle t+1.
  - At t+1, mem_data_i is valid and is written into the FIFO at the end of t+1.
  - v_o=1 and data_o=head from t+2 (latency 2).
  - data_o is held stable while v_o=1 and yumi_i=0.
- Write path:
  - Writes produce no response and consume no credit.
  - A write may be accepted in the cycle after a read.
  - Read-after-write to the same address returns the new data (the macro orders them).
- FIFO:
  - Same-cycle enqueue and dequeue keeps occ unchanged.
  - Enqueue into a full FIFO cannot occur; credit prevents it. An assertion flags it.
  - yumi_i with v_o=0 is illegal. An assertion flags it.
- Occupancy:
  - occ width is $clog2(resp_els_p+1).
  - FIFO pointers wrap at resp_els_p (non-power-of-2 allowed).
- Reset mid-operation:
  - Drops FIFO contents and inflight immediately; the pending read data is discarded.
  - Restarts INIT (if enabled).

Optional Feature:
- MEM_ADAPTER_INIT_EN defined:
  - After reset, INIT state runs.
  - Issues els_p writes: mem_v_o=1, mem_w_o=1, mem_data_o=0, mem_w_mask_o all ones, mem_addr_o = 0..els_p-1, one per cycle, starting the first cycle after reset deasserts.
  - ready_o=0 throughout.
  - init_done_o rises the cycle after the write to address els_p-1.
- Not defined: no INIT state, no sweep; init_done_o=1 one cycle after reset deasserts.

Test Plan:
- Reset, macro undefined -> init_done_o=1 and ready_o=1 one cycle after reset falls; mem_v_o=0 while idle.
- MEM_ADAPTER_INIT_EN, els_p=512 -> 512 consecutive zero writes to addr 0..511; init_done_o rises at cycle 513 after reset; a read of addr 37 then returns 0.
- Write addr 5 = 0xDEAD_BEEF_0000_1111 with full mask, then read addr 5 -> v_o two cycles after read acceptance, data_o=0xDEAD_BEEF_0000_1111.
- Partial mask: write 0xFFFF... with w_mask_i=0x0000_0000_0000_00FF over old value 0 -> readback 0x0000_0000_0000_00FF.
- Back-to-back reads of addr 0..7 with yumi_i=1 every cycle -> one acceptance per cycle, responses in order.
- Back-to-back reads with yumi_i=0 -> ready_o drops after 3 accepted reads; data_o stays stable; releasing yumi_i drains all 3 in order.
- Reset asserted with 2 FIFO entries plus 1 inflight -> v_o=0 next cycle; no stale response appears afterward.

Source files
------------

// File: rtl/hard_mem_1rw_req_adapter_if.sv
// Client/memory-side signal bundle for hard_mem_1rw_req_adapter.
// slave  : adapter view (client request/response + wrapper port).
// master : environment view (client and hard-memory wrapper).
interface hard_mem_1rw_req_adapter_if #(
  parameter int width_p = 64,
  parameter int els_p   = 512
);
  localparam int addr_width_lp = $clog2(els_p);

  logic                     v_i;
  logic                     ready_o;
  logic                     w_i;
  logic [addr_width_lp-1:0] addr_i;
  logic [width_p-1:0]       data_i;
  logic [width_p-1:0]       w_mask_i;
  logic                     v_o;
  logic [width_p-1:0]       data_o;
  logic                     yumi_i;
  logic                     mem_v_o;
  logic                     mem_w_o;
  logic [addr_width_lp-1:0] mem_addr_o;
  logic [width_p-1:0]       mem_data_o;
  logic [width_p-1:0]       mem_w_mask_o;
  logic [width_p-1:0]       mem_data_i;
  logic                     init_done_o;

  modport slave (
    input  v_i, w_i, addr_i, data_i, w_mask_i, yumi_i, mem_data_i,
    output ready_o, v_o, data_o, mem_v_o, mem_w_o, mem_addr_o,
           mem_data_o, mem_w_mask_o, init_done_o
  );

  modport master (
    output v_i, w_i, addr_i, data_i, w_mask_i, yumi_i, mem_data_i,
    input  ready_o, v_o, data_o, mem_v_o, mem_w_o, mem_addr_o,
           mem_data_o, mem_w_mask_o, init_done_o
  );
endinterface

// File: rtl/hard_mem_1rw_req_adapter.sv
// Valid/ready front end for a 1rw bit-mask hard-memory wrapper.
// Tracks the one-cycle macro read latency, parks read data in a small
// credit-managed response FIFO, and backpressures the client.
// Optional zero sweep after reset: define MEM_ADAPTER_INIT_EN.
module hard_mem_1rw_req_adapter #(
  parameter int width_p    = 64,
  parameter int els_p      = 512,
  parameter int resp_els_p = 3
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  hard_mem_1rw_req_adapter_if.slave bus
);
  localparam int addr_width_lp = $clog2(els_p);
  localparam int ptr_width_lp  = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;
  localparam int occ_width_lp  = $clog2(resp_els_p + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_READY} state_e;

  // The sweep must write address 0 in the first cycle out of reset, so the
  // reset state is INIT itself rather than passing through IDLE.
`ifdef MEM_ADAPTER_INIT_EN
  localparam state_e reset_state_lp = ST_INIT;
`else
  localparam state_e reset_state_lp = ST_IDLE;
`endif

  state_e                   state_q, state_d;
`ifdef MEM_ADAPTER_INIT_EN
  logic [addr_width_lp-1:0] init_addr_q, init_addr_d;
`endif
  logic                     inflight_q, inflight_d;
  logic [occ_width_lp-1:0]  occ_q, occ_d;
  logic [ptr_width_lp-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [width_p-1:0]       fifo_q [resp_els_p];

  logic                     init_done, credit_ok, ready, accept, enq, deq, resp_v;
  logic                     mem_v, mem_w;
  logic [addr_width_lp-1:0] mem_addr;
  logic [width_p-1:0]       mem_data, mem_w_mask;

  // Handshake and credit: outstanding reads (queued + in flight) bound acceptance.
  always_comb begin
    init_done = (state_q == ST_READY);
    credit_ok = (32'(occ_q) + 32'(inflight_q)) < 32'(resp_els_p);
    ready     = init_done & credit_ok & ~reset_i;
    accept    = bus.v_i & ready;
    resp_v    = (occ_q != '0);
    enq       = inflight_q;
    deq       = bus.yumi_i & resp_v;
  end

  // Wrapper port: client pass-through on acceptance, sweep writes during INIT.
  always_comb begin
    mem_v      = accept;
    mem_w      = accept & bus.w_i;
    mem_addr   = bus.addr_i;
    mem_data   = bus.data_i;
    mem_w_mask = (accept & bus.w_i) ? bus.w_mask_i : '0;
`ifdef MEM_ADAPTER_INIT_EN
    if ((state_q == ST_INIT) && !reset_i) begin
      mem_v      = 1'b1;
      mem_w      = 1'b1;
      mem_addr   = init_addr_q;
      mem_data   = '0;
      mem_w_mask = '1;
    end
`endif
  end

  // Next state: IDLE/INIT lead to READY; INIT advances one address per cycle.
  always_comb begin
    state_d = state_q;
`ifdef MEM_ADAPTER_INIT_EN
    init_addr_d = init_addr_q;
`endif
    case (state_q)
      ST_IDLE: state_d = ST_READY;
      ST_INIT: begin
`ifdef MEM_ADAPTER_INIT_EN
        init_addr_d = init_addr_q + addr_width_lp'(1);
        if (init_addr_q == addr_width_lp'(els_p - 1)) state_d = ST_READY;
`else
        state_d = ST_READY;
`endif
      end
      default: ;
    endcase
  end

  // Response FIFO bookkeeping; pointers wrap at resp_els_p.
  always_comb begin
    inflight_d = accept & ~bus.w_i;
    occ_d      = occ_q;
    if (enq && !deq)      occ_d = occ_q + occ_width_lp'(1);
    else if (!enq && deq) occ_d = occ_q - occ_width_lp'(1);
    wptr_d = wptr_q;
    if (enq) wptr_d = (wptr_q == ptr_width_lp'(resp_els_p - 1)) ? '0 : wptr_q + ptr_width_lp'(1);
    rptr_d = rptr_q;
    if (deq) rptr_d = (rptr_q == ptr_width_lp'(resp_els_p - 1)) ? '0 : rptr_q + ptr_width_lp'(1);
  end

  // Control registers with synchronous reset; reset discards queued/in-flight reads.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= reset_state_lp;
`ifdef MEM_ADAPTER_INIT_EN
      init_addr_q <= '0;
`endif
      inflight_q <= 1'b0;
      occ_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
`ifdef MEM_ADAPTER_INIT_EN
      init_addr_q <= init_addr_d;
`endif
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // FIFO storage captures macro read data the cycle after the read issued.
  always_ff @(posedge clk_i) begin
    if (enq && !reset_i) fifo_q[wptr_q] <= bus.mem_data_i;
  end

  // Protocol checks: credit must prevent overflow; yumi only when valid.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      a_no_overflow: assert (!(enq && (occ_q == occ_width_lp'(resp_els_p))));
      a_yumi_legal:  assert (!(bus.yumi_i && !resp_v));
    end
  end

  assign bus.ready_o      = ready;
  assign bus.v_o          = resp_v;
  assign bus.data_o       = fifo_q[rptr_q];
  assign bus.init_done_o  = init_done;
  assign bus.mem_v_o      = mem_v;
  assign bus.mem_w_o      = mem_w;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_data_o   = mem_data;
  assign bus.mem_w_mask_o = mem_w_mask;
endmodule
